// File: rtl/keypad_scan_ctrl_if.sv
// Key FIFO read port of the keypad scanner: head code, ASCII character and valid/ready handshake.
interface keypad_scan_ctrl_if;
    logic [3:0] key_code;
    logic [6:0] ascii;
    logic       key_valid;
    logic       key_ready;

    modport master (output key_code, output ascii, output key_valid, input key_ready);
    modport slave  (input key_code, input ascii, input key_valid, output key_ready);
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad sequencer: one-hot row drive, per-sweep column snapshot, debounce FSM,
// and a 4-entry key FIFO read through a valid/ready handshake.
module keypad_scan_ctrl #(
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned DEBOUNCE = 3
) (
    input  logic                       clk50,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [3:0]                 Columna,
    output logic [3:0]                 Fila,
    keypad_scan_ctrl_if.master         key_if,
    output logic                       overflow,
    input  logic                       ovf_clr
);

    localparam int unsigned TW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CW    = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned PW    = 2;
    localparam int unsigned FW    = 3;

    typedef enum logic [1:0] {
        S_RELEASED,
        S_PRESS_CHK,
        S_PRESSED,
        S_RELEASE_CHK
    } db_state_t;

    logic [3:0]    r_fila;
    logic [1:0]    r_row;
    logic [TW-1:0] r_timer;
    logic [11:0]   r_snap;
    db_state_t     r_state;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_cand;
    logic [3:0]    r_mem [DEPTH];
    logic [PW-1:0] r_rptr;
    logic [PW-1:0] r_wptr;
    logic [FW-1:0] r_count;
    logic [3:0]    r_key_code;
    logic [6:0]    r_ascii;
    logic          r_key_valid;
    logic          r_overflow;

    logic          w_sample;
    logic          w_sweep_done;
    logic [15:0]   w_sweep;
    logic [4:0]    w_ones;
    logic [3:0]    w_idx;
    logic          w_cand_ok;
    logic [31:0]   w_cnt_inc;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_push_acc;
    logic          w_ovf_set;
    logic [FW-1:0] w_count_nxt;
    logic [PW-1:0] w_rptr_nxt;
    logic [3:0]    w_head_code;

    function automatic logic [6:0] f_ascii(input logic [3:0] code);
        case (code)
            4'd0:  f_ascii = 7'h31;
            4'd1:  f_ascii = 7'h32;
            4'd2:  f_ascii = 7'h33;
            4'd3:  f_ascii = 7'h41;
            4'd4:  f_ascii = 7'h34;
            4'd5:  f_ascii = 7'h35;
            4'd6:  f_ascii = 7'h36;
            4'd7:  f_ascii = 7'h42;
            4'd8:  f_ascii = 7'h37;
            4'd9:  f_ascii = 7'h38;
            4'd10: f_ascii = 7'h39;
            4'd11: f_ascii = 7'h43;
            4'd12: f_ascii = 7'h2A;
            4'd13: f_ascii = 7'h30;
            4'd14: f_ascii = 7'h23;
            4'd15: f_ascii = 7'h44;
        endcase
    endfunction

    // Rows 0..2 live in the shift register; row 3 is taken straight from the pins.
    assign w_sample     = enable && (r_fila != 4'b0000) && (r_timer == TW'(SCAN_DIV - 1));
    assign w_sweep_done = w_sample && (r_row == 2'd3);
    assign w_sweep      = {Columna, r_snap};
    assign w_cnt_inc    = 32'(r_cnt) + 32'd1;

    always_comb begin
        w_ones = 5'd0;
        w_idx  = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (w_sweep[i]) begin
                w_ones = w_ones + 5'd1;
                w_idx  = 4'(i);
            end
        end
    end

    assign w_cand_ok = (w_ones == 5'd1);

    always_comb begin
        w_push = 1'b0;
        if (w_sweep_done && w_cand_ok) begin
            case (r_state)
                S_RELEASED:  w_push = (DEBOUNCE == 1);
                S_PRESS_CHK: w_push = (w_idx == r_cand) && (w_cnt_inc >= DEBOUNCE);
                default:     w_push = 1'b0;
            endcase
        end
    end

    // Pop is only possible when non-empty, so a full FIFO with a pop can still take a push.
    assign w_pop       = r_key_valid && key_if.key_ready;
    assign w_full      = (r_count == FW'(DEPTH));
    assign w_push_acc  = w_push && (!w_full || w_pop);
    assign w_ovf_set   = w_push && w_full && !w_pop;
    assign w_count_nxt = r_count + FW'(w_push_acc) - FW'(w_pop);
    assign w_rptr_nxt  = r_rptr + PW'(w_pop);
    assign w_head_code = (w_push_acc && ((r_count - FW'(w_pop)) == FW'(0))) ? w_idx : r_mem[w_rptr_nxt];

    always_ff @(posedge clk50) begin
        if (rst) begin
            r_fila      <= 4'b0000;
            r_row       <= 2'd0;
            r_timer     <= TW'(0);
            r_snap      <= 12'd0;
            r_state     <= S_RELEASED;
            r_cnt       <= CW'(0);
            r_cand      <= 4'd0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= 4'd0;
            r_rptr      <= PW'(0);
            r_wptr      <= PW'(0);
            r_count     <= FW'(0);
            r_key_code  <= 4'd0;
            r_ascii     <= 7'd0;
            r_key_valid <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (!enable) begin
                r_fila  <= 4'b0000;
                r_row   <= 2'd0;
                r_timer <= TW'(0);
                r_snap  <= 12'd0;
                r_state <= S_RELEASED;
                r_cnt   <= CW'(0);
            end else if (r_fila == 4'b0000) begin
                r_fila  <= 4'b0001;
                r_row   <= 2'd0;
                r_timer <= TW'(0);
            end else if (w_sample) begin
                r_timer <= TW'(0);
                r_row   <= r_row + 2'd1;
                r_fila  <= {r_fila[2:0], r_fila[3]};
                r_snap  <= {Columna, r_snap[11:4]};
                if (r_row == 2'd3) begin
                    case (r_state)
                        S_RELEASED: begin
                            if (w_cand_ok) begin
                                r_cand  <= w_idx;
                                r_cnt   <= CW'(1);
                                r_state <= (DEBOUNCE == 1) ? S_PRESSED : S_PRESS_CHK;
                            end
                        end
                        S_PRESS_CHK: begin
                            if (!w_cand_ok) begin
                                r_state <= S_RELEASED;
                                r_cnt   <= CW'(0);
                            end else if (w_idx == r_cand) begin
                                if (w_cnt_inc >= DEBOUNCE) r_state <= S_PRESSED;
                                else                       r_cnt   <= CW'(w_cnt_inc);
                            end else begin
                                r_cand <= w_idx;
                                r_cnt  <= CW'(1);
                            end
                        end
                        S_PRESSED: begin
                            if (!w_cand_ok) begin
                                r_cnt   <= CW'(1);
                                r_state <= (DEBOUNCE == 1) ? S_RELEASED : S_RELEASE_CHK;
                            end
                        end
                        S_RELEASE_CHK: begin
                            if (w_cand_ok) begin
                                r_state <= S_PRESSED;
                            end else if (w_cnt_inc >= DEBOUNCE) begin
                                r_state <= S_RELEASED;
                                r_cnt   <= CW'(0);
                            end else begin
                                r_cnt <= CW'(w_cnt_inc);
                            end
                        end
                        default: r_state <= S_RELEASED;
                    endcase
                end
            end else begin
                r_timer <= r_timer + TW'(1);
            end

            if (w_push_acc) begin
                r_mem[r_wptr] <= w_idx;
                r_wptr        <= r_wptr + PW'(1);
            end
            r_rptr      <= w_rptr_nxt;
            r_count     <= w_count_nxt;
            r_key_valid <= (w_count_nxt != FW'(0));
            if (w_count_nxt != FW'(0)) begin
                r_key_code <= w_head_code;
                r_ascii    <= f_ascii(w_head_code);
            end

            if (w_ovf_set)    r_overflow <= 1'b1;
            else if (ovf_clr) r_overflow <= 1'b0;
        end
    end

    assign Fila             = r_fila;
    assign overflow         = r_overflow;
    assign key_if.key_code  = r_key_code;
    assign key_if.ascii     = r_ascii;
    assign key_if.key_valid = r_key_valid;

endmodule

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

Sequencing controller for the 4x4 matrix keypad. It drives the rows one at a time, samples the columns, debounces the result over full sweeps, and queues each accepted key press as a 4-bit code plus its ASCII character in a 4-entry FIFO. The SoC CSR side reads the FIFO through a valid/ready handshake. The block replaces free-running divider-based scanning with a single-clock, reset-controlled sequencer.

## Interface

Parameters:
- SCAN_DIV, default 50000: clock cycles each row is driven (dwell); minimum 2.
- DEBOUNCE, default 3: consecutive identical sweeps needed to accept a press or a release; minimum 1.

Ports:
- clk50, input, 1: system clock. One clock domain; all logic is on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- enable, input, 1: scanning enable.
- Columna, input, 4: keypad column lines, active-high (1 = key closed on the driven row).
- Fila, output, 4: row drive, one-hot, active-high.
- key_code, output, 4: FIFO head, encoded as row*4 + col.
- ascii, output, 7: ASCII character of the FIFO head.
- key_valid, output, 1: FIFO is not empty.
- key_ready, input, 1: consumer accepts the head entry.
- overflow, output, 1: sticky flag, set when a press is dropped because the FIFO is full.
- ovf_clr, input, 1: clears overflow.

## Operation

- Reset values:
  - Fila = 0000; key_code = 0; ascii = 0; key_valid = 0; overflow = 0.
  - FIFO empty; row index 0; dwell timer 0; debounce FSM in RELEASED with count 0.
- Row sequencer:
  - While enable = 1, Fila = 0001, 0010, 0100, 1000 (row 0..3), cycling.
  - Each row is held SCAN_DIV cycles.
  - Columna is sampled on the last dwell cycle (timer = SCAN_DIV-1) into snapshot bits [row*4 +: 4].
  - The sample of row 3 completes a sweep.
- Sweep classification:
  - Exactly one snapshot bit set → candidate = that index.
  - Zero bits set → NONE.
  - More than one bit set (multi-key or ghosting) → NONE.
- Debounce FSM, evaluated once per completed sweep, with count cnt:
  - RELEASED: on a candidate, latch it, set cnt = 1, go to PRESS_CHK (or go straight to accept if DEBOUNCE = 1).
  - PRESS_CHK:
    - Same candidate: cnt++. When cnt reaches DEBOUNCE, push the latched key and go to PRESSED.
    - Different candidate: re-latch it, cnt = 1.
    - NONE: go to RELEASED.
  - PRESSED:
    - NONE: cnt = 1, go to RELEASE_CHK.
    - Any candidate: stay in PRESSED (no repeat, no rollover).
  - RELEASE_CHK:
    - NONE: cnt++. When cnt reaches DEBOUNCE, go to RELEASED.
    - Any candidate: go back to PRESSED.
- ASCII map (row, then cols 0..3):
  - row 0: '1' 0x31, '2' 0x32, '3' 0x33, 'A' 0x41
  - row 1: '4' 0x34, '5' 0x35, '6' 0x36, 'B' 0x42
  - row 2: '7' 0x37, '8' 0x38, '9' 0x39, 'C' 0x43
  - row 3: '*' 0x2A, '0' 0x30, '#' 0x23, 'D' 0x44
  - Stored alongside the code, or decoded from key_code at the head.
- FIFO:
  - Depth 4, with 2-bit read/write pointers plus a 3-bit count. Pointers wrap 3→0.
  - Pop occurs when key_valid and key_ready are both 1.
  - key_code and ascii are valid only while key_valid = 1; their value otherwise is don't-care.
- Boundary conditions:
  - Push while full with no pop: the entry is dropped and overflow is set.
  - Push and pop in the same cycle while full: both take effect, count stays 4, no overflow.
  - Push and pop in the same cycle while empty: the push is accepted; no pop occurs.
  - ovf_clr and a new overflow in the same cycle: set wins.
  - enable deasserted:
    - Fila = 0000 on the next cycle; timer and row index reset to 0; debounce FSM goes to RELEASED; any partial sweep is discarded.
    - FIFO contents and the handshake remain fully operational.
  - Re-enable restarts at row 0 with a fresh sweep.
  - rst mid-sweep or mid-debounce: all state returns to reset values on the next edge; queued keys are lost.

## Timing

- Sweep period: 4*SCAN_DIV cycles.
- Settling: the first sample of a row is taken SCAN_DIV-1 cycles after Fila changes.
- Press latency:
  - A push happens at the end of the DEBOUNCE-th consecutive full sweep containing the key.
  - key_valid rises the cycle after the push edge, i.e. the cycle after the row-3 sample that completes that sweep.
  - Worst case: DEBOUNCE+1 sweeps from contact.
- Handshake:
  - Pop takes effect at the edge where valid and ready are both 1.
  - The next entry (or key_valid = 0) appears the following cycle.
  - key_ready may be held high permanently; back-to-back pops then run one per cycle.
- overflow clears the cycle after ovf_clr.

## Test plan

Use SCAN_DIV = 4 and DEBOUNCE = 2 throughout (sweep = 16 cycles).

1. Reset, then check the row sequence:
   - Stimulus: release rst with enable = 1.
   - Required: Fila = 0001 for 4 cycles, then 0010, 0100, 1000, 0001.
   - All outputs are at their reset values during rst.
2. Single press of key '5' (row 1, col 1):
   - Stimulus: assert Columna = 0010 whenever Fila = 0010, held for 3 sweeps, with key_ready = 0.
   - Required: after the 2nd sweep, key_valid = 1, key_code = 5, ascii = 0x35. Exactly one entry is queued.
3. Bounce and release:
   - Stimulus: press '#' (key_code 14) for 1 sweep, then NONE, then 2 sweeps of '#'.
   - Required: exactly one push, with ascii = 0x23.
   - After that, 1 NONE sweep followed by '#' again must produce no push.
4. Multi-key:
   - Stimulus: Columna = 0011 on row 0 for 4 sweeps.
   - Required: no push; key_valid stays 0.
5. FIFO full and overflow:
   - Stimulus: queue 5 distinct presses (1, 2, 3, A, 4) with key_ready = 0.
   - Required: overflow = 1; popping yields 0x31, 0x32, 0x33, 0x41, after which key_valid = 0.
   - Pulsing ovf_clr clears overflow.
6. enable = 0 mid-debounce:
   - Stimulus: one sweep of '7', then enable = 0 for 10 cycles, re-enable, one more '7' sweep.
   - Required: Fila = 0000 while disabled; no push. Only a second fresh '7' sweep pushes 0x37.
